// File: rtl/scaler_pkg.sv
// Shared zoom encoding and default screen/grid/reciprocal constants for the
// pixel-to-grid coordinate scaler.
package scaler_pkg;

  typedef enum logic [1:0] {
    ZOOM_1X = 2'd0,
    ZOOM_2X = 2'd1,
    ZOOM_4X = 2'd2
  } zoom_e;

  localparam int unsigned SCREEN_W = 1024;
  localparam int unsigned SCREEN_H = 768;
  localparam int unsigned GRID_N   = 128;

  localparam int unsigned COL_NUM_DEF   = 1;
  localparam int unsigned COL_SHIFT_DEF = 3;
  localparam int unsigned ROW_NUM_DEF   = 171;
  localparam int unsigned ROW_SHIFT_DEF = 10;

  // The unused request code 3 falls back to the widest zoom.
  function automatic zoom_e zoom_decode(input logic [1:0] req);
    return (req == 2'd3) ? ZOOM_4X : zoom_e'(req);
  endfunction

endpackage

// File: rtl/scale_axis.sv
// One axis of the scaler: offset/window test, reciprocal multiply, shift and
// clamp, as a three-register pipeline.
module scale_axis
  import scaler_pkg::*;
#(
  parameter int unsigned IN_W   = 12,
  parameter int unsigned OUT_W  = 7,
  parameter int unsigned OFFSET = 0,
  parameter int unsigned EXTENT = SCREEN_W,
  parameter int unsigned NUM    = COL_NUM_DEF,
  parameter int unsigned SHIFT  = COL_SHIFT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IN_W-1:0]  pixel,
  input  zoom_e            zoom,
  output logic [OUT_W-1:0] scaled,
  output logic             win
);

  localparam int unsigned PW = IN_W + 12;
  localparam logic [IN_W:0] OFF = (IN_W+1)'(OFFSET);
  localparam logic [IN_W:0] EXT = (IN_W+1)'(EXTENT);

  logic [IN_W:0]   diff;
  logic            win_now;
  logic [IN_W-1:0] d_s1;
  logic            win_s1;
  logic [PW-1:0]   prod_s2;
  logic            win_s2;
  logic [PW-1:0]   quot;

  always_comb begin
    diff    = {1'b0, pixel} - OFF;
    win_now = ({1'b0, pixel} >= OFF) && (diff < EXT);
  end

  // zoom is aligned with prod_s2, so each pixel uses its own shift.
  always_comb quot = prod_s2 >> (SHIFT + int'(zoom));

  always_ff @(posedge clock) begin
    if (reset) begin
      d_s1    <= '0;
      win_s1  <= 1'b0;
      prod_s2 <= '0;
      win_s2  <= 1'b0;
      scaled  <= '0;
      win     <= 1'b0;
    end else begin
      d_s1    <= diff[IN_W-1:0];
      win_s1  <= win_now;
      prod_s2 <= PW'(d_s1) * PW'(NUM);
      win_s2  <= win_s1;
      scaled  <= (|quot[PW-1:OUT_W]) ? '1 : quot[OUT_W-1:0];
      win     <= win_s2;
    end
  end

endmodule

// File: rtl/grid_scaler.sv
// Maps DTG pixel coordinates to world-map grid coordinates with a window flag
// and a frame-synchronous zoom; fixed 3-cycle latency, one pixel per clock.
module grid_scaler
  import scaler_pkg::*;
#(
  parameter int unsigned IN_W       = 12,
  parameter int unsigned OUT_W      = $clog2(GRID_N),
  parameter int unsigned COL_OFFSET = 0,
  parameter int unsigned ROW_OFFSET = 0,
  parameter int unsigned COL_EXTENT = SCREEN_W,
  parameter int unsigned ROW_EXTENT = SCREEN_H,
  parameter int unsigned COL_NUM    = COL_NUM_DEF,
  parameter int unsigned COL_SHIFT  = COL_SHIFT_DEF,
  parameter int unsigned ROW_NUM    = ROW_NUM_DEF,
  parameter int unsigned ROW_SHIFT  = ROW_SHIFT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  pixel_column,
  input  logic [IN_W-1:0]  pixel_row,
  input  logic [1:0]       zoom_req,
  output logic             out_valid,
  output logic [OUT_W-1:0] scaled_column,
  output logic [OUT_W-1:0] scaled_row,
  output logic             in_window,
  output logic [1:0]       zoom_active
);

  logic       frame_start;
  logic [1:0] zoom_pending;
  zoom_e      zoom_active_q;
  zoom_e      zoom_px;
  zoom_e      zoom_s1;
  zoom_e      zoom_s2;
  logic       valid_s1;
  logic       valid_s2;

  logic [OUT_W-1:0] col_q;
  logic [OUT_W-1:0] row_q;
  logic             win_col;
  logic             win_row;

  // The frame-start pixel already takes the newly latched zoom.
  always_comb begin
    frame_start = in_valid && (pixel_column == '0) && (pixel_row == '0);
    zoom_px     = frame_start ? zoom_decode(zoom_pending) : zoom_active_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      zoom_pending  <= '0;
      zoom_active_q <= ZOOM_1X;
      zoom_s1       <= ZOOM_1X;
      zoom_s2       <= ZOOM_1X;
      valid_s1      <= 1'b0;
      valid_s2      <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      zoom_pending  <= zoom_req;
      zoom_active_q <= zoom_px;
      zoom_s1       <= zoom_px;
      zoom_s2       <= zoom_s1;
      valid_s1      <= in_valid;
      valid_s2      <= valid_s1;
      out_valid     <= valid_s2;
    end
  end

  scale_axis #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .OFFSET(COL_OFFSET),
    .EXTENT(COL_EXTENT),
    .NUM   (COL_NUM),
    .SHIFT (COL_SHIFT)
  ) u_col (
    .clock (clock),
    .reset (reset),
    .pixel (pixel_column),
    .zoom  (zoom_s2),
    .scaled(col_q),
    .win   (win_col)
  );

  scale_axis #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .OFFSET(ROW_OFFSET),
    .EXTENT(ROW_EXTENT),
    .NUM   (ROW_NUM),
    .SHIFT (ROW_SHIFT)
  ) u_row (
    .clock (clock),
    .reset (reset),
    .pixel (pixel_row),
    .zoom  (zoom_s2),
    .scaled(row_q),
    .win   (win_row)
  );

  always_comb begin
    in_window     = win_col && win_row;
    scaled_column = in_window ? col_q : '0;
    scaled_row    = in_window ? row_q : '0;
    zoom_active   = zoom_active_q;
  end

endmodule
